// File: rtl/hms_pkg.sv
// ============================================================================
// Module      : hms_pkg
// Description : Shared constants, state encoding and helper functions for
//               the HMS(E) merge-sorter write-side feeder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hms_pkg;

  // Default records-per-word geometry.
  localparam int HMS_E_LOG = 2;
  localparam int E         = 1 << HMS_E_LOG;

  // Upper bound on a word width handled by the terminator helper.
  localparam int HMS_MAX_W = 2048;

  // Feeder routing / terminator states.
  localparam int         STATE_W = 2;
  localparam logic [1:0] S_A     = 2'd0;
  localparam logic [1:0] S_B     = 2'd1;
  localparam logic [1:0] S_TA    = 2'd2;
  localparam logic [1:0] S_TB    = 2'd3;

  // Records per word for an arbitrary E_LOG.
  function automatic int hms_num_recs(input int e_log);
    return 1 << e_log;
  endfunction

  // Word whose every record has an all-ones key and a zero payload, so the
  // merger always sees this entry as the largest and drains the run ahead.
  function automatic logic [HMS_MAX_W-1:0] hms_term_word(input int datw,
                                                         input int keyw,
                                                         input int e_log);
    logic [HMS_MAX_W-1:0] key_ones;
    logic [HMS_MAX_W-1:0] word;
    key_ones = ~({HMS_MAX_W{1'b1}} << keyw);
    word     = '0;
    for (int r = 0; r < (1 << e_log); r++) begin
      word = word | (key_ones << (r * datw));
    end
    return word;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hms_order_checker.sv
// ============================================================================
// Module      : hms_order_checker
// Description : Checks that every accepted word continues its run in
//               non-descending key order and raises a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_order_checker
  import hms_pkg::*;
#(
  parameter int E_LOG = 2,
  parameter int KEYW  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [(KEYW<<E_LOG)-1:0] keys_i,
  input  logic                     accept_i,
  input  logic                     last_i,
  output logic                     err_o
);

  localparam int NREC = hms_num_recs(E_LOG);

  logic [KEYW-1:0] last_key_q;
  logic [KEYW-1:0] last_key_d;
  logic            err_q;
  logic            err_d;
  logic            w_viol;

  // Detect a descending step inside the word or against the previous word.
  always_comb begin
    w_viol = (keys_i[KEYW-1:0] < last_key_q);
    for (int i = 0; i < NREC - 1; i++) begin
      if (keys_i[(i+1)*KEYW +: KEYW] < keys_i[i*KEYW +: KEYW]) begin
        w_viol = 1'b1;
      end
    end
  end

  // Track the run's last key (cleared at run end) and latch violations.
  always_comb begin
    last_key_d = last_key_q;
    err_d      = err_q;
    if (accept_i) begin
      last_key_d = last_i ? '0 : keys_i[(NREC-1)*KEYW +: KEYW];
      err_d      = err_q | w_viol;
    end
  end

  // Checker state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_key_q <= '0;
      err_q      <= 1'b0;
    end else begin
      last_key_q <= last_key_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

`default_nettype wire

// File: rtl/hms_run_feeder.sv
// ============================================================================
// Module      : hms_run_feeder
// Description : Deals sorted runs alternately into input FIFOs A and B of the
//               HMS(E) merge sorter, back-pressures the source and flags
//               out-of-order runs. Optional run terminator words are enabled
//               by defining HMS_RUN_TERMINATOR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hms_run_feeder
  import hms_pkg::*;
#(
  parameter int E_LOG = 2,
  parameter int DATW  = 64,
  parameter int KEYW  = 32,
  parameter int RUN_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [(DATW<<E_LOG)-1:0] DIN,
  input  logic                     DINEN,
  input  logic                     DINLAST,
  output logic                     STALL,
  input  logic                     FULL_A,
  input  logic                     FULL_B,
  output logic [(DATW<<E_LOG)-1:0] DOT,
  output logic                     ENQ_A,
  output logic                     ENQ_B,
  output logic [RUN_W-1:0]         RUNS,
  output logic                     ERR
);

  localparam int NREC  = hms_num_recs(E_LOG);
  localparam int WORDW = DATW << E_LOG;

`ifdef HMS_RUN_TERMINATOR_EN
  localparam logic [WORDW-1:0] TERM_WORD = WORDW'(hms_term_word(DATW, KEYW, E_LOG));
`endif

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [WORDW-1:0]   dot_q;
  logic [WORDW-1:0]   dot_d;
  logic               enq_a_q;
  logic               enq_a_d;
  logic               enq_b_q;
  logic               enq_b_d;
  logic [RUN_W-1:0]   runs_q;
  logic [RUN_W-1:0]   runs_d;
  logic               w_stall;
  logic               w_accept;
  logic [(KEYW<<E_LOG)-1:0] w_keys;

  // Gather the key field of every record for the order checker.
  for (genvar g = 0; g < NREC; g++) begin : g_keys
    assign w_keys[g*KEYW +: KEYW] = DIN[g*DATW +: KEYW];
  end

  // Stall on the current target's full flag only; terminator states always stall.
  always_comb begin
    w_stall = 1'b1;
    case (state_q)
      S_A:       w_stall = FULL_A;
      S_B:       w_stall = FULL_B;
      S_TA, S_TB: w_stall = 1'b1;
      default:   w_stall = 1'b1;
    endcase
  end

  assign w_accept = DINEN & ~w_stall;

  // Route accepted words to the current target and advance at run end.
  always_comb begin
    state_d = state_q;
    dot_d   = dot_q;
    enq_a_d = 1'b0;
    enq_b_d = 1'b0;
    runs_d  = runs_q;
    case (state_q)
      S_A: begin
        if (w_accept) begin
          dot_d   = DIN;
          enq_a_d = 1'b1;
          if (DINLAST) begin
            runs_d  = runs_q + {{(RUN_W-1){1'b0}}, 1'b1};
`ifdef HMS_RUN_TERMINATOR_EN
            state_d = S_TA;
`else
            state_d = S_B;
`endif
          end
        end
      end
      S_B: begin
        if (w_accept) begin
          dot_d   = DIN;
          enq_b_d = 1'b1;
          if (DINLAST) begin
            runs_d  = runs_q + {{(RUN_W-1){1'b0}}, 1'b1};
`ifdef HMS_RUN_TERMINATOR_EN
            state_d = S_TB;
`else
            state_d = S_A;
`endif
          end
        end
      end
`ifdef HMS_RUN_TERMINATOR_EN
      S_TA: begin
        if (!FULL_A) begin
          dot_d   = TERM_WORD;
          enq_a_d = 1'b1;
          state_d = S_B;
        end
      end
      S_TB: begin
        if (!FULL_B) begin
          dot_d   = TERM_WORD;
          enq_b_d = 1'b1;
          state_d = S_A;
        end
      end
`endif
      default: state_d = S_A;
    endcase
  end

  // Feeder state and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_A;
      dot_q   <= '0;
      enq_a_q <= 1'b0;
      enq_b_q <= 1'b0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      dot_q   <= dot_d;
      enq_a_q <= enq_a_d;
      enq_b_q <= enq_b_d;
      runs_q  <= runs_d;
    end
  end

  hms_order_checker #(
    .E_LOG (E_LOG),
    .KEYW  (KEYW)
  ) u_order_checker (
    .clk_i    (CLK),
    .rst_ni   (RST),
    .keys_i   (w_keys),
    .accept_i (w_accept),
    .last_i   (DINLAST),
    .err_o    (ERR)
  );

  assign STALL = w_stall;
  assign DOT   = dot_q;
  assign ENQ_A = enq_a_q;
  assign ENQ_B = enq_b_q;
  assign RUNS  = runs_q;

endmodule

`default_nettype wire

// File: tb/tb_hms_run_feeder.sv
// ============================================================================
// Module      : tb_hms_run_feeder
// Description : Scoreboard bench for hms_run_feeder with a run-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hms_run_feeder;

  localparam int E_LOG = 2;
  localparam int DATW  = 64;
  localparam int KEYW  = 32;
  localparam int RUN_W = 16;
  localparam int NREC  = 1 << E_LOG;
  localparam int WW    = DATW * NREC;

  logic             CLK = 1'b0;
  logic             RST;
  logic [WW-1:0]    DIN = '0;
  logic             DINEN = 1'b0;
  logic             DINLAST = 1'b0;
  logic             FULL_A = 1'b0;
  logic             FULL_B = 1'b0;
  logic             STALL;
  logic [WW-1:0]    DOT;
  logic             ENQ_A;
  logic             ENQ_B;
  logic [RUN_W-1:0] RUNS;
  logic             ERR;

  hms_run_feeder #(
    .E_LOG (E_LOG),
    .DATW  (DATW),
    .KEYW  (KEYW),
    .RUN_W (RUN_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .DIN     (DIN),
    .DINEN   (DINEN),
    .DINLAST (DINLAST),
    .STALL   (STALL),
    .FULL_A  (FULL_A),
    .FULL_B  (FULL_B),
    .DOT     (DOT),
    .ENQ_A   (ENQ_A),
    .ENQ_B   (ENQ_B),
    .RUNS    (RUNS),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [WW-1:0]    word;
    bit               to_b;
    bit               err;
    logic [RUN_W-1:0] runs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int tests = 0;
  int fails = 0;

  // Run-level reference model state.
  int               m_run_idx = 0;
  logic [RUN_W-1:0] m_runs = '0;
  bit               m_err = 1'b0;
  logic [KEYW-1:0]  m_last_key = '0;

  // FIFO full-flag stimulus controls.
  int full_a_hold = 0;
  bit rand_full   = 1'b0;
  bit full_b_force = 1'b0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WW-1:0] term_word();
    logic [WW-1:0] w;
    for (int r = 0; r < NREC; r++) begin
      w[r*DATW +: DATW] = {{(DATW-KEYW){1'b0}}, {KEYW{1'b1}}};
    end
    return w;
  endfunction

  function automatic logic [WW-1:0] mk(input logic [KEYW-1:0] k0, input logic [KEYW-1:0] k1,
                                       input logic [KEYW-1:0] k2, input logic [KEYW-1:0] k3);
    logic [WW-1:0] w;
    logic [KEYW-1:0] k [NREC];
    k[0] = k0; k[1] = k1; k[2] = k2; k[3] = k3;
    for (int r = 0; r < NREC; r++) begin
      w[r*DATW +: DATW] = {(DATW-KEYW)'($urandom), k[r]};
    end
    return w;
  endfunction

  // Reference model: applies the ordering rules to one accepted word.
  task automatic model_accept(input logic [WW-1:0] w, input bit last);
    logic [KEYW-1:0] k [NREC];
    bit viol;
    exp_t e;
    for (int r = 0; r < NREC; r++) k[r] = w[r*DATW +: KEYW];
    viol = (k[0] < m_last_key);
    for (int r = 0; r + 1 < NREC; r++) if (k[r+1] < k[r]) viol = 1'b1;
    if (viol) m_err = 1'b1;
    m_last_key = last ? '0 : k[NREC-1];
    if (last) m_runs = m_runs + 1'b1;
    e.word = w; e.to_b = (m_run_idx % 2) == 1; e.err = m_err; e.runs = m_runs;
    sb.push_back(e);
    if (last) begin
`ifdef HMS_RUN_TERMINATOR_EN
      e.word = term_word();
      sb.push_back(e);
`endif
      m_run_idx++;
    end
  endtask

  task automatic set_full();
    if (full_a_hold > 0) begin
      FULL_A = 1'b1;
      full_a_hold--;
    end else begin
      FULL_A = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
    FULL_B = full_b_force ? 1'b1 : (rand_full ? ($urandom_range(0, 3) == 0) : 1'b0);
  endtask

  task automatic send_word(input logic [WW-1:0] w, input bit last);
    int waited;
    bit done;
    bit exp_stall;
    waited = 0;
    done = 1'b0;
    @(negedge CLK);
    DIN = w; DINEN = 1'b1; DINLAST = last;
    while (!done) begin
      set_full();
      #1;
      exp_stall = ((m_run_idx % 2) == 0) ? FULL_A : FULL_B;
`ifdef HMS_RUN_TERMINATOR_EN
      if (exp_stall) chk("stall_on_full", WW'(STALL), WW'(1'b1));
`else
      chk("stall", WW'(STALL), WW'(exp_stall));
`endif
      if (!STALL) begin
        model_accept(w, last);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          chk("accept_timeout", WW'(1'b1), WW'(1'b0));
          done = 1'b1;
        end else begin
          @(negedge CLK);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DINEN = 1'b0; DINLAST = 1'b0;
      set_full();
    end
  endtask

  task automatic send_rand_run(input int nwords);
    logic [KEYW-1:0] cur;
    logic [KEYW-1:0] k [NREC];
    cur = KEYW'($urandom_range(0, 100));
    for (int wi = 0; wi < nwords; wi++) begin
      for (int r = 0; r < NREC; r++) begin
        cur = cur + KEYW'($urandom_range(0, 3));
        k[r] = cur;
      end
      send_word(mk(k[0], k[1], k[2], k[3]), wi == nwords - 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  // Scoreboard monitor: every enqueue must match the next expected word.
  always @(negedge CLK) begin
    if (RST) begin
      if (ENQ_A || ENQ_B) begin
        chk("enq_exclusive", WW'(ENQ_A & ENQ_B), WW'(1'b0));
        if (sb.size() == 0) begin
          chk("unexpected_enq", WW'(1'b1), WW'(1'b0));
        end else begin
          mon_e = sb.pop_front();
          chk("dot", DOT, mon_e.word);
          chk("enq_b", WW'(ENQ_B), WW'(mon_e.to_b));
          chk("runs", WW'(RUNS), WW'(mon_e.runs));
          chk("err", WW'(ERR), WW'(mon_e.err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, including STALL following FULL_A during reset.
    RST = 1'b1;
    #1 RST = 1'b0;
    FULL_A = 1'b1;
    #2;
    chk("rst_stall_full", WW'(STALL), WW'(1'b1));
    chk("rst_dot", DOT, '0);
    chk("rst_enq", WW'({ENQ_A, ENQ_B}), WW'(2'b00));
    chk("rst_runs", WW'(RUNS), '0);
    chk("rst_err", WW'(ERR), '0);
    FULL_A = 1'b0;
    #1 chk("rst_stall_nfull", WW'(STALL), WW'(1'b0));
    @(negedge CLK); #2 RST = 1'b1;

    // Two ascending three-word runs, no back-pressure.
    send_word(mk(1, 2, 3, 4), 1'b0);
    send_word(mk(5, 6, 7, 8), 1'b0);
    send_word(mk(9, 10, 11, 12), 1'b1);
    send_word(mk(1, 2, 3, 4), 1'b0);
    send_word(mk(5, 6, 7, 8), 1'b0);
    send_word(mk(9, 10, 11, 12), 1'b1);
    idle(3);
    chk("two_runs_count", WW'(RUNS), WW'(16'd2));
    chk("two_runs_err", WW'(ERR), WW'(1'b0));

    // FULL_A held for four cycles at the start of a run to A.
    full_a_hold = 4;
    send_rand_run(3);
    // One-word run to B, then FULL_B held while routing to A.
    send_rand_run(1);
    full_b_force = 1'b1;
    send_rand_run(4);
    full_b_force = 1'b0;
    idle(3);

    // Randomised ordered runs with random back-pressure on both FIFOs.
    rand_full = 1'b1;
    for (int r = 0; r < 40; r++) send_rand_run($urandom_range(1, 4));
    rand_full = 1'b0;
    idle(4);
    chk("rand_err_clear", WW'(ERR), WW'(1'b0));

    // Intra-word order violation, then a fresh run starting at key 0.
    send_word(mk(5, 3, 7, 8), 1'b0);
    send_word(mk(9, 9, 10, 11), 1'b1);
    send_word(mk(0, 1, 2, 3), 1'b1);
    idle(3);
    chk("err_sticky", WW'(ERR), WW'(1'b1));

    // Reset mid-run with target B and a word in flight.
    if ((m_run_idx % 2) == 0) send_rand_run(1);
    send_word(mk(20, 21, 22, 23), 1'b0);
    @(posedge CLK); #2;
    RST = 1'b0; DINEN = 1'b0; DINLAST = 1'b0;
    #1;
    chk("mid_rst_dot", DOT, '0);
    chk("mid_rst_enq", WW'({ENQ_A, ENQ_B}), WW'(2'b00));
    chk("mid_rst_runs", WW'(RUNS), '0);
    chk("mid_rst_err", WW'(ERR), '0);
    sb.delete();
    m_run_idx = 0; m_runs = '0; m_err = 1'b0; m_last_key = '0;
    @(negedge CLK); #2 RST = 1'b1;

    // After reset the first run goes to A again, the next to B.
    send_rand_run(2);
    send_rand_run(2);
    idle(5);
    chk("sb_drained", WW'(sb.size()), '0);
    chk("final_runs", WW'(RUNS), WW'(m_runs));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hms_run_feeder.md
# hms_run_feeder

Write-side front end of the HMS(E) merge sorter. Takes one stream of E-record words (E = 1<<E_LOG) with run-boundary marks. Deals whole sorted runs alternately into the two SRL-based input FIFOs (A, B) that the selector logic dequeues from. Applies FIFO back-pressure to the upstream source and flags any run that arrives out of ascending key order.

## Interface
Parameters:
- E_LOG, 2, log2 of records per word
- DATW, 64, record width in bits
- KEYW, 32, key width; the key is bits [KEYW-1:0] of each record
- RUN_W, 16, width of the dispatched-run counter

Ports:
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  reset; asynchronous, active-low
- DIN  in  DATW<<E_LOG  input word; record i occupies [DATW*(i+1)-1:DATW*i]
- DINEN  in  1  DIN valid
- DINLAST  in  1  DIN is the last word of the current run; qualified by DINEN
- STALL  out  1  upstream must hold DIN/DINEN/DINLAST while high
- FULL_A  in  1  full flag of FIFO A
- FULL_B  in  1  full flag of FIFO B
- DOT  out  DATW<<E_LOG  word to enqueue; shared by both FIFOs
- ENQ_A  out  1  enqueue DOT into FIFO A
- ENQ_B  out  1  enqueue DOT into FIFO B
- RUNS  out  RUN_W  count of runs completely dispatched
- ERR  out  1  sticky order-violation flag

## Operation
- Accept condition: a word is accepted when DINEN && !STALL.
- Routing states are S_A and S_B. Reset state is S_A.
- STALL = (S_A && FULL_A) || (S_B && FULL_B) || (state is a terminator state).
- Accepted word: DOT <= DIN. ENQ_A <= 1 in S_A, or ENQ_B <= 1 in S_B. Otherwise both ENQ go low next cycle.
- Accepted word with DINLAST set:
  - RUNS increments (wraps modulo 2^RUN_W).
  - Without the terminator feature: S_A toggles to S_B, or S_B to S_A.
  - With the terminator feature: S_A goes to S_TA, and S_B goes to S_TB.
- ENQ_A and ENQ_B are never both high. DOT holds its value when no enqueue occurs.
- Order check, per accepted word:
  - Violation if any key[i+1] < key[i] inside the word.
  - Violation if key[0] < last_key, where last_key is key[E-1] of the previous accepted word of the same run.
  - After a DINLAST word, last_key is cleared to 0.
  - Equal keys are legal.
  - A violation sets ERR on the next cycle. ERR stays set until reset. Data still flows.
- Reset (asynchronous, any time): DOT=0, ENQ_A=0, ENQ_B=0, RUNS=0, ERR=0, last_key=0, state S_A. A word in flight is dropped.
- Combinational output during reset: STALL equals FULL_A.

## Timing
- Latency: 1 cycle from the accepted edge to ENQ_x/DOT.
- Throughput: one word per cycle while the target FIFO is not full.
- The FIFO full flag asserts at depth-1. The single enqueue already registered when FULL rises therefore still fits.
- FULL of the non-target FIFO never stalls the feeder.
- A single-word run (DINLAST on its first word) is legal and switches target after one word.
- A FULL change and DINLAST in the same cycle: STALL is evaluated with the pre-edge state only.
- The terminator state costs one extra cycle per run, or more if the FIFO is full.

## Configuration
- Macro: HMS_RUN_TERMINATOR_EN.
- Defined:
  - States S_TA and S_TB exist.
  - In S_Tx with FULL_x low: DOT <= terminator word, ENQ_x <= 1, then go to the opposite routing state.
  - In S_Tx with FULL_x high: wait.
  - STALL is high throughout S_Tx.
  - Terminator word: every record's key is all ones and every payload bit is 0. This lets the merger drain each run.
- Undefined: no terminator states and no terminator words. Runs are packed back to back.

## Structure
- Package hms_pkg holds:
  - the state encoding (S_A, S_B, S_TA, S_TB);
  - the record-count constant E = 1<<E_LOG;
  - a function building the terminator word from DATW, KEYW, E_LOG.
- One sub-module, hms_order_checker, holds last_key, the intra-word and cross-word compares, and the ERR register. The feeder drives its accept and last strobes.

## Test plan
- Two runs of 3 words with keys 1..12 ascending and DINLAST on words 3 and 6, FIFOs never full → words 1-3 on ENQ_A, words 4-6 on ENQ_B, RUNS=2, ERR=0.
- FULL_A=1 for 4 cycles during run A → STALL high for exactly those 4 cycles, no ENQ_A while held, no word lost or duplicated.
- FULL_B=1 while routing to A → STALL stays 0 and ENQ_A continues every cycle.
- Word keys {5,3,7,8} → ERR=1 the cycle after acceptance, word still enqueued. Then a new run starting at key 0 → ERR stays 1.
- With HMS_RUN_TERMINATOR_EN: one-word run to A → next cycle STALL=1, DOT has keys 0xFFFFFFFF ×4 with ENQ_A=1, then routing moves to B.
- RST pulsed low mid-run with the target in S_B → all outputs 0 immediately and the next accepted word goes to A.
